// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS decode stage: opcodes, the
// instruction class enum and the decoded-instruction record.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Widest immediate the decoder produces; narrower outputs take the low bits,
  // which is exact for both sign- and zero-extension.
  localparam int IMM_MAX = 64;

  typedef enum logic [1:0] {
    CLASS_R = 2'd0,
    CLASS_I = 2'd1,
    CLASS_J = 2'd2
  } instr_class_t;

  typedef struct packed {
    logic [5:0]         opcode;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic [5:0]         funct;
    logic [IMM_MAX-1:0] imm;
    logic [31:0]        jtarget;
    instr_class_t       iclass;
    logic [31:0]        pc;
    logic               illegal;
  } decoded_t;

  // True for the opcodes this core implements.
  function automatic logic opcode_supported(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH-entry valid/ready queue holding packed decoded records.
// Head entry is read combinationally so a push into an empty queue is
// visible right after the pushing edge. DEPTH need not be a power of two.
module decode_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  // No bypass when full: in_ready looks only at the stored count.
  assign in_ready  = (count_reg < CNT_W'(DEPTH)) && !reset;
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      // Storage for one entry; cleared on reset so idle outputs read as zero.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= in_data;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  assign out_data = mem[rd_ptr_reg];

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: combinational field split, class,
// immediate extension and jump target, buffered in a decode_fifo.
// Optional feature: define DECODE_ILLEGAL_EN to flag and store
// unsupported opcodes; otherwise out_illegal is tied low.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int IMM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_opcode,
  output logic [5:0]           out_funct,
  output logic [4:0]           out_rs,
  output logic [4:0]           out_rt,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_shamt,
  output logic [IMM_WIDTH-1:0] out_imm,
  output logic [31:0]          out_jtarget,
  output logic [1:0]           out_class,
  output logic [31:0]          out_pc,
  output logic                 out_illegal
);

`ifdef DECODE_ILLEGAL_EN
  localparam int ILL_W = 1;
`else
  localparam int ILL_W = 0;
`endif
  localparam int PAY_W = 32 + IMM_WIDTH + 32 + 2 + 32 + ILL_W;

  decoded_t         dec;
  logic [15:0]      imm16;
  logic [31:0]      pc_plus4;
  logic [PAY_W-1:0] wr_data;
  logic [PAY_W-1:0] rd_data;
  logic             dec_unused;

  assign imm16    = in_instr[15:0];
  assign pc_plus4 = in_pc + 32'd4;

  // Combinational decode of the instruction presented by fetch.
  always_comb begin
    dec         = '0;
    dec.opcode  = in_instr[31:26];
    dec.rs      = in_instr[25:21];
    dec.rt      = in_instr[20:16];
    dec.rd      = in_instr[15:11];
    dec.shamt   = in_instr[10:6];
    dec.funct   = in_instr[5:0];
    dec.pc      = in_pc;
    dec.jtarget = {pc_plus4[31:28], in_instr[25:0], 2'b00};

    case (in_instr[31:26])
      OP_ANDI, OP_ORI, OP_XORI: dec.imm = {{(IMM_MAX-16){1'b0}}, imm16};
      OP_LUI:                   dec.imm = {{(IMM_MAX-32){imm16[15]}}, imm16, 16'h0000};
      default:                  dec.imm = {{(IMM_MAX-16){imm16[15]}}, imm16};
    endcase

    case (in_instr[31:26])
      OP_RTYPE:    dec.iclass = CLASS_R;
      OP_J, OP_JAL: dec.iclass = CLASS_J;
      default:     dec.iclass = CLASS_I;
    endcase

`ifdef DECODE_ILLEGAL_EN
    dec.illegal = !opcode_supported(in_instr[31:26]);
`endif
  end

  // Record bits that are not stored in this build (upper immediate bits,
  // and the illegal flag when it is disabled) are intentionally dropped.
  assign dec_unused = ^dec;

`ifdef DECODE_ILLEGAL_EN
  assign wr_data = {dec.opcode, dec.rs, dec.rt, dec.rd, dec.shamt, dec.funct,
                    dec.imm[IMM_WIDTH-1:0], dec.jtarget, dec.iclass, dec.pc,
                    dec.illegal};
  assign {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
          out_imm, out_jtarget, out_class, out_pc, out_illegal} = rd_data;
`else
  assign wr_data = {dec.opcode, dec.rs, dec.rt, dec.rd, dec.shamt, dec.funct,
                    dec.imm[IMM_WIDTH-1:0], dec.jtarget, dec.iclass, dec.pc};
  assign {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
          out_imm, out_jtarget, out_class, out_pc} = rd_data;
  assign out_illegal = 1'b0;
`endif

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (rd_data)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (DEPTH=2, IMM_WIDTH=32).
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [31:0] out_imm;
  logic [31:0] out_jtarget;
  logic [1:0]  out_class;
  logic [31:0] out_pc;
  logic        out_illegal;

  decode_stage #(.DEPTH(2), .IMM_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_funct   (out_funct),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_imm     (out_imm),
    .out_jtarget (out_jtarget),
    .out_class   (out_class),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops     = 0;
  int pop_cyc [$];
  logic [191:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors with hand-computed immediate, jump target and class.
  logic [31:0] v_instr [16];
  logic [31:0] v_imm   [16];
  logic [31:0] v_jt    [16];
  logic [1:0]  v_cls   [16];
  logic        v_ill   [16];

  logic [191:0] act_vec;
  assign act_vec = {61'd0, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
                    out_imm, out_jtarget, out_class, out_pc, out_illegal};

  function automatic logic [31:0] pc_of(input int idx);
    if (idx == 4)  return 32'h4000_0000;
    if (idx == 11) return 32'h1FFF_FFFC;
    return 32'h0000_1000 + 32'(idx * 4);
  endfunction

  function automatic logic [191:0] exp_vec(input int idx);
    logic [31:0]  ins;
    logic [130:0] v;
    ins = v_instr[idx];
    v = {ins[31:26], ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[5:0],
         v_imm[idx], v_jt[idx], v_cls[idx], pc_of(idx), v_ill[idx]};
    return {61'd0, v};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", act_vec);
      end else begin
        logic [191:0] e;
        e = exp_q.pop_front();
        $display("txn %0d pc=%h opcode=%h class=%0d imm=%h jt=%h ill=%0d",
                 pops, out_pc, out_opcode, out_class, out_imm, out_jtarget, out_illegal);
        check("entry", act_vec, e);
      end
      pops++;
      pop_cyc.push_back(cyc);
    end
  end

  // Present vector idx until accepted; expectation is queued at acceptance.
  task automatic send(input int idx, output int waited);
    in_valid = 1'b1;
    in_instr = v_instr[idx];
    in_pc    = pc_of(idx);
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited <= 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 192'(waited), 192'(0));
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp_vec(idx));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stalls;
    int p0;
    int n;

    v_instr = '{32'h01095020, 32'h2008FFFF, 32'h3508FFFF, 32'h3C081234,
                32'h08000010, 32'h8D090004, 32'hAD090008, 32'h1109FFFE,
                32'h31088000, 32'h39088000, 32'h21088000, 32'h0C000100,
                32'h00084080, 32'h3C01FFFF, 32'h2A09000A, 32'hFC000000};
    v_imm   = '{32'h00005020, 32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000,
                32'h00000010, 32'h00000004, 32'h00000008, 32'hFFFFFFFE,
                32'h00008000, 32'h00008000, 32'hFFFF8000, 32'h00000100,
                32'h00004080, 32'hFFFF0000, 32'h0000000A, 32'h00000000};
    v_jt    = '{32'h04254080, 32'h0023FFFC, 32'h0423FFFC, 32'h002048D0,
                32'h40000040, 32'h04240010, 32'h04240020, 32'h0427FFF8,
                32'h04220000, 32'h04220000, 32'h04220000, 32'h20000400,
                32'h00210200, 32'h0007FFFC, 32'h08240028, 32'h00000000};
    v_cls   = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1,
                2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 16; i++) v_ill[i] = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    v_ill[15] = 1'b1;
`endif

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 192'(out_valid), 192'(0));
    check("reset_in_ready", 192'(in_ready), 192'(0));
    check("reset_outputs_zero", act_vec, 192'(0));
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", 192'(in_ready), 192'(1));

    // Single R-type with one-edge latency, then a jump
    @(posedge clk); #1;
    send(0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_out_valid", 192'(out_valid), 192'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Fill DEPTH=2 with consumer stalled; third waits until after the first pop
    send(1, w);
    send(2, w);
    in_valid = 1'b1;
    in_instr = v_instr[3];
    in_pc    = pc_of(3);
    @(negedge clk);
    check("full_in_ready", 192'(in_ready), 192'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("no_bypass_in_ready", 192'(in_ready), 192'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("accept_after_pop", 192'(in_ready), 192'(1));
    if (in_ready) exp_q.push_back(exp_vec(3));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n = pop_cyc.size();
    check("flow_pops_consecutive", 192'(pop_cyc[n-1] - pop_cyc[n-3]), 192'(2));

    // Continuous stream of 10 with out_ready held high
    stalls = 0;
    for (int i = 5; i <= 14; i++) begin
      send(i, w);
      stalls += w;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_no_stall", 192'(stalls), 192'(0));
    n = pop_cyc.size();
    check("stream_no_bubbles", 192'(pop_cyc[n-1] - pop_cyc[n-10]), 192'(9));

    // Reset mid-stream with two entries queued
    out_ready = 1'b0;
    send(5, w);
    send(6, w);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("midreset_out_valid", 192'(out_valid), 192'(0));
    check("midreset_in_ready", 192'(in_ready), 192'(0));
    check("midreset_outputs_zero", act_vec, 192'(0));
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("postreset_in_ready", 192'(in_ready), 192'(1));
    check("postreset_queue_empty", 192'(out_valid), 192'(0));
    out_ready = 1'b1;
    p0 = pops;
    send(15, w);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("postreset_single_output", 192'(pops - p0), 192'(1));
    check("scoreboard_drained", 192'(exp_q.size()), 192'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined MIPS instruction-decode stage with valid/ready handshakes on both sides.
- Splits each 32-bit instruction into all R/I/J fields and classifies the format.
- Produces an extended immediate and a resolved jump target.
- Buffers decoded results in a DEPTH-entry output queue so the fetch side can run ahead of a stalled execute stage.
- Sits between instruction fetch and register-file read/execute.

## Interface
Parameters:
- DEPTH, 2, number of decoded entries buffered (≥1; need not be a power of two)
- IMM_WIDTH, 32, width of the extended immediate output (32..64)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction word
- in_pc  in  32  address of in_instr
- out_valid  out  1  head entry holds a decoded instruction
- out_ready  in  1  consumer accepts head entry
- out_opcode, out_funct  out  6 each  instr[31:26], instr[5:0]
- out_rs, out_rt, out_rd, out_shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
- out_imm  out  IMM_WIDTH  extended immediate
- out_jtarget  out  32  jump target
- out_class  out  2  0=R, 1=I, 2=J (3 unused)
- out_pc  out  32  in_pc carried through
- out_illegal  out  1  unsupported opcode (see Configuration)

## Operation
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count < DEPTH) and not in reset. There is no full-queue bypass: when full, in_ready is 0 even if a pop occurs in the same cycle.
- Decode is combinational on in_instr/in_pc and written into the tail entry at push.
- Class rules:
  - opcode 0x00 → R
  - 0x02 and 0x03 → J
  - everything else → I
- Raw fields (rs..funct) are always extracted, regardless of class.
- Immediate rules:
  - 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend imm16.
  - 0x0F (lui): {imm16, 16'h0}, then sign-extended to IMM_WIDTH.
  - All others: sign-extend imm16.
- out_jtarget = {(in_pc+4)[31:28], instr[25:0], 2'b00}. It is computed for every instruction and is meaningful only when class = J.
- Queue pointers:
  - Read and write pointers each wrap explicitly from DEPTH-1 to 0.
  - count is $clog2(DEPTH+1) bits wide.
  - Simultaneous push and pop leaves count unchanged.
- Outputs always present the head entry. Values are don't-care while out_valid = 0, except that they are all zero after reset.

## Timing
- Latency: an instruction pushed at edge N is visible with out_valid = 1 after edge N, provided the queue was empty.
- Throughput: one instruction per cycle when out_ready is held high.
- Reset (asynchronous assert, any cycle, including mid-transfer):
  - Pointers, count and all stored entries are cleared.
  - out_valid = 0; all data outputs = 0; in_ready = 0 while reset is asserted.
  - Queued instructions are discarded.
  - in_ready rises combinationally once reset deasserts.
- out_valid depends only on registered state, with no combinational path from in_valid. in_ready depends only on count and reset, with no path from out_ready.

## Configuration
- DECODE_ILLEGAL_EN defined:
  - out_illegal = 1 for any opcode outside {0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F, 0x23, 0x2B}.
  - The flag is stored with the entry.
  - The illegal instruction is still queued normally.
- DECODE_ILLEGAL_EN undefined: the out_illegal port exists and is tied to 0, and no storage is allocated for it.

## Structure
- Package decode_pkg holds:
  - opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW)
  - the instr_class_t enum (CLASS_R, CLASS_I, CLASS_J)
  - the packed decoded_t struct (fields, imm, jtarget, class, pc, illegal)
- One sub-module, decode_fifo: generic DEPTH-entry queue of decoded_t with a valid/ready interface. decode_stage is the combinational decoder plus an instance of decode_fifo.

## Test plan
- Push 0x01095020 (add) → class R, rs=8, rt=9, rd=10, shamt=0, funct=0x20.
- Push 0x2008FFFF (addi) then 0x3508FFFF (ori) then 0x3C081234 (lui), IMM_WIDTH=32, expected out_imm:
  - addi → 0xFFFFFFFF
  - ori → 0x0000FFFF
  - lui → 0x12340000
- Push 0x08000010 (j) with in_pc=0x4000_0000 → class J, out_jtarget=0x40000040.
- DEPTH=2, out_ready=0, in_valid held high with 3 instructions:
  - Two pushes are accepted, then in_ready=0.
  - Raise out_ready → entries pop in order, one per cycle, and the third instruction is accepted on the cycle after the first pop.
- Continuous push and pop with out_ready=1 for 10 instructions → 10 outputs in order, with no bubbles after the first.
- Assert reset mid-stream with 2 entries queued → out_valid=0 immediately and all outputs are 0. After deassert, the next push appears alone. With DECODE_ILLEGAL_EN, push opcode 0x3F → out_illegal=1.
